sar_out_fifo: RTL and testbench

Result-capture stage directly downstream of the SAR conversion controller. Samples the 8-bit `sar` code on each rising edge of `eoc`, queues it in a small synchronous FIFO and presents it to the readout logic over a valid/ready handshake. A sticky overflow flag reports dropped codes. An optional compile-time 4-sample averager reduces the output rate.

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_sync_fifo.sv | 90 +++++++++
 rtl/sar_out_fifo.sv | 108 ++++++++++
 tb/tb_sar_out_fifo.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sar_pkg                                                                  |
// | Constants shared by the SAR conversion controller and its output stage.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sar_pkg;

   localparam int SAR_W         = 8;
   localparam int SAR_OUT_DEPTH = 8;
   localparam int SAR_AVG_LOG2  = 2;
   localparam int SAR_AVG_N     = 1 << SAR_AVG_LOG2;

endpackage
`default_nettype wire

// File: rtl/sar_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sar_sync_fifo                                                            |
// | Show-ahead synchronous FIFO with a registered head word.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sar_sync_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_push_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic [LW-1:0] o_level,
   output logic          o_full,
   output logic          o_empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [LW-1:0] r_level;
   logic [W-1:0]  r_head;

   logic          w_full;
   logic          w_empty;
   logic          w_pop_ok;
   logic          w_push_ok;
   logic [AW:0]   w_rptr_nxt;
   logic [LW-1:0] w_level_nxt;
   logic [W-1:0]  w_head_nxt;

   assign w_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_empty    = (r_wptr == r_rptr);
   assign w_pop_ok   = i_pop & ~w_empty;
   assign w_push_ok  = i_push & (~w_full | w_pop_ok);
   assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop_ok};

   always_comb begin
      w_level_nxt = r_level;
      if (w_push_ok && !w_pop_ok) begin
         w_level_nxt = r_level + LW'(1);
      end else if (w_pop_ok && !w_push_ok) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   // The word being written this cycle becomes the head when it lands in the
   // slot the read pointer moves to; otherwise the head comes from storage.
   always_comb begin
      w_head_nxt = r_mem[w_rptr_nxt[AW-1:0]];
      if (w_push_ok && (w_rptr_nxt[AW-1:0] == r_wptr[AW-1:0])) begin
         w_head_nxt = i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr[AW-1:0]] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_head  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         end
         r_rptr  <= w_rptr_nxt;
         r_level <= w_level_nxt;
         r_head  <= w_head_nxt;
      end
   end

   assign o_data  = r_head;
   assign o_level = r_level;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/sar_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sar_out_fifo                                                             |
// | Captures SAR codes on eoc rising edges into a FIFO with sticky overflow. |
// | Define SAR_OUT_AVG_EN to push the truncated mean of every 4 captures.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sar_out_fifo
   import sar_pkg::*;
#(
   parameter int DEPTH = SAR_OUT_DEPTH,
   parameter int W     = SAR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [W-1:0]                 sar_in,
   input  logic                         eoc,
   input  logic                         rd_ready,
   output logic                         rd_valid,
   output logic [W-1:0]                 rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         ovf,
   input  logic                         ovf_clr
);

   logic         r_eoc_d;
   logic         r_ovf;
   logic         w_cap;
   logic         w_push;
   logic [W-1:0] w_push_data;
   logic         w_full;
   logic         w_empty;
   logic         w_drop;

   assign w_cap = eoc & ~r_eoc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_eoc_d <= 1'b0;
      end else begin
         r_eoc_d <= eoc;
      end
   end

`ifdef SAR_OUT_AVG_EN
   logic [W+1:0] r_acc;
   logic [1:0]   r_cnt;
   logic [W+1:0] w_sum;
   logic         w_last;

   assign w_sum       = r_acc + {2'b00, sar_in};
   assign w_last      = (r_cnt == 2'(SAR_AVG_N - 1));
   assign w_push      = w_cap & w_last;
   assign w_push_data = W'(w_sum >> SAR_AVG_LOG2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_cap) begin
         if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 2'd1;
         end
      end
   end
`else
   assign w_push      = w_cap;
   assign w_push_data = sar_in;
`endif

   sar_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (rd_ready),
      .o_data      (rd_data),
      .o_level     (level),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign rd_valid = ~w_empty;

   // A pop in the same cycle frees a slot, so only a full FIFO without a pop drops.
   assign w_drop = w_push & w_full & ~(rd_ready & rd_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sar_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sar_out_fifo                                                          |
// | Scoreboard bench for sar_out_fifo (direct or SAR_OUT_AVG_EN build).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sar_out_fifo;

   localparam int DEPTH = 8;
   localparam int W     = 8;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  sar_in = '0;
   logic          eoc = 1'b0;
   logic          rd_ready = 1'b0;
   logic          rd_valid;
   logic [W-1:0]  rd_data;
   logic [LW-1:0] level;
   logic          ovf;
   logic          ovf_clr = 1'b0;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  q[$];

   always #5 clk = ~clk;

   sar_out_fifo #(.DEPTH(DEPTH), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .sar_in   (sar_in),
      .eoc      (eoc),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .level    (level),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // One-cycle eoc pulse followed by one low cycle so the next pulse is a new edge.
   task automatic capture_drive(input logic [W-1:0] code);
      sar_in = code;
      eoc    = 1'b1;
      @(negedge clk);
      eoc    = 1'b0;
      @(negedge clk);
   endtask

   task automatic capture(input logic [W-1:0] code);
      if (q.size() < DEPTH) q.push_back(code);
      capture_drive(code);
   endtask

   task automatic drain();
      rd_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== q[0]) begin
            errors++;
            $display("FAIL drain[%0d]: got valid=%b data=%h required valid=1 data=%h",
                     i, rd_valid, rd_data, q[0]);
         end
         void'(q.pop_front());
         @(negedge clk);
      end
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || level !== '0) begin
         errors++;
         $display("FAIL drain_empty: got valid=%b level=%0d required valid=0 level=0",
                  rd_valid, level);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== '0 || level !== '0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b data=%h level=%0d ovf=%b required all 0",
                  rd_valid, rd_data, level, ovf);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

`ifndef SAR_OUT_AVG_EN
   task automatic test_single();
      sar_in = 8'hA5;
      eoc    = 1'b1;
      q.push_back(8'hA5);
      @(negedge clk);
      eoc = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== q[0] || level !== LW'(1)) begin
         errors++;
         $display("FAIL single_latency: got valid=%b data=%h level=%0d required valid=1 data=%h level=1",
                  rd_valid, rd_data, level, q[0]);
      end
      rd_ready = 1'b1;
      void'(q.pop_front());
      @(negedge clk);
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || level !== '0) begin
         errors++;
         $display("FAIL single_pop: got valid=%b level=%0d required valid=0 level=0",
                  rd_valid, level);
      end
      // Reading an empty FIFO must be ignored.
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || level !== '0) begin
         errors++;
         $display("FAIL empty_read: got valid=%b level=%0d required valid=0 level=0",
                  rd_valid, level);
      end
   endtask

   task automatic test_long_eoc();
      sar_in = 8'h3C;
      eoc    = 1'b1;
      q.push_back(8'h3C);
      repeat (5) @(negedge clk);
      eoc = 1'b0;
      @(negedge clk);
      checks++;
      if (level !== LW'(1)) begin
         errors++;
         $display("FAIL long_eoc_level: got %0d required 1", level);
      end
      drain();
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 9; i++) capture(W'(i));
      checks++;
      if (level !== LW'(DEPTH) || ovf !== 1'b1) begin
         errors++;
         $display("FAIL fill_overflow: got level=%0d ovf=%b required level=%0d ovf=1",
                  level, ovf, DEPTH);
      end
      drain();
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got %b required 1", ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clr: got %b required 0", ovf);
      end
   endtask

   task automatic test_full_pop_capture();
      for (int i = 0; i < DEPTH; i++) capture(W'(8'h20 + i));
      sar_in   = 8'h77;
      eoc      = 1'b1;
      rd_ready = 1'b1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== q[0]) begin
         errors++;
         $display("FAIL full_pop_head: got valid=%b data=%h required valid=1 data=%h",
                  rd_valid, rd_data, q[0]);
      end
      void'(q.pop_front());
      q.push_back(8'h77);
      @(negedge clk);
      eoc      = 1'b0;
      rd_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (level !== LW'(DEPTH) || ovf !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_capture: got level=%0d ovf=%b required level=%0d ovf=0",
                  level, ovf, DEPTH);
      end
      drain();
   endtask

   task automatic test_set_vs_clear();
      for (int i = 0; i < DEPTH; i++) capture(W'(8'h40 + i));
      sar_in  = 8'h99;
      eoc     = 1'b1;
      ovf_clr = 1'b1;
      @(negedge clk);
      eoc     = 1'b0;
      ovf_clr = 1'b0;
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL set_vs_clear: got ovf=%b required 1", ovf);
      end
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL clear_alone: got ovf=%b required 0", ovf);
      end
      drain();
   endtask

   task automatic test_reset_midstream();
      capture(8'h11);
      capture(8'h22);
      capture(8'h33);
      rst    = 1'b1;
      sar_in = 8'h5A;
      eoc    = 1'b1;
      @(negedge clk);
      q.delete();
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== '0 || level !== '0) begin
         errors++;
         $display("FAIL midstream_reset: got valid=%b data=%h level=%0d required 0 0 0",
                  rd_valid, rd_data, level);
      end
      rst = 1'b0;
      q.push_back(8'h5A);
      repeat (2) @(negedge clk);
      eoc = 1'b0;
      checks++;
      if (level !== LW'(1) || rd_data !== q[0]) begin
         errors++;
         $display("FAIL eoc_after_reset: got level=%0d data=%h required level=1 data=%h",
                  level, rd_data, q[0]);
      end
      drain();
   endtask
`else
   task automatic test_avg();
      logic [W+1:0] sum;
      logic [W-1:0] codes [4];
      codes[0] = 8'h10; codes[1] = 8'h11; codes[2] = 8'h12; codes[3] = 8'h14;
      sum = '0;
      for (int i = 0; i < 3; i++) begin
         sum += {2'b00, codes[i]};
         capture_drive(codes[i]);
      end
      checks++;
      if (level !== '0) begin
         errors++;
         $display("FAIL avg_partial: got level=%0d required 0", level);
      end
      sum += {2'b00, codes[3]};
      q.push_back(W'(sum >> 2));
      capture_drive(codes[3]);
      checks++;
      if (level !== LW'(1)) begin
         errors++;
         $display("FAIL avg_push: got level=%0d required 1", level);
      end
      drain();
   endtask

   task automatic test_avg_reset();
      capture_drive(8'h55);
      capture_drive(8'h55);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) capture_drive(8'h80);
      checks++;
      if (level !== '0) begin
         errors++;
         $display("FAIL avg_reset_partial: got level=%0d required 0", level);
      end
      q.push_back(8'h80);
      capture_drive(8'h80);
      checks++;
      if (level !== LW'(1)) begin
         errors++;
         $display("FAIL avg_reset_push: got level=%0d required 1", level);
      end
      drain();
   endtask
`endif

   initial begin
      test_reset();
`ifndef SAR_OUT_AVG_EN
      test_single();
      test_long_eoc();
      test_fill_overflow();
      test_full_pop_capture();
      test_set_vs_clear();
      test_reset_midstream();
`else
      test_avg();
      test_avg_reset();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
